prod_win_acc: RTL and testbench

Windowed accumulator that sits directly downstream of the last-two-values multiplier and consumes its 2w-bit product stream. It sums `n` accepted products, or fewer on an early flush, and presents the window sum with a valid/ready handshake. The output is held until the consumer accepts it, and upstream is back-pressured meanwhile. It feeds the averaging/report stage.

---
 rtl/prod_win_acc.sv | 121 ++++++++++++
 tb/tb_prod_win_acc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/prod_win_acc.sv
// Windowed sum of an unsigned product stream with a valid/ready output held until accepted.
// Define PROD_WIN_ACC_SAT_EN to saturate the window sum instead of wrapping it.
module prod_win_acc #(
    parameter int unsigned pw = 8,
    parameter int unsigned n  = 4,
    parameter int unsigned aw = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [pw-1:0] in,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic          flush,
    output logic [aw-1:0] out,
    output logic [3:0]    out_cnt,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic          ovf
);

    typedef enum logic [1:0] {StIdle, StAcc, StFull} state_e;

    state_e        state_q, state_d;
    logic [aw-1:0] acc_q, acc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          win_ovf_q, win_ovf_d;
    logic [aw-1:0] out_q, out_d;
    logic [3:0]    out_cnt_q, out_cnt_d;
    logic          out_vld_q, out_vld_d;
    logic          ovf_q, ovf_d;

    logic          acc_in;
    logic          out_take;
    logic          close;
    logic [aw:0]   sum;
    logic          carry;
    logic [aw-1:0] add_acc;
    logic [aw-1:0] win_acc;
    logic [3:0]    win_cnt;
    logic          win_ovf;

    assign in_rdy  = !out_vld_q | out_rdy;
    assign out     = out_q;
    assign out_cnt = out_cnt_q;
    assign out_vld = out_vld_q;
    assign ovf     = ovf_q;

    // Running window value including this cycle's accepted sample, if any.
    always_comb begin
        acc_in   = in_vld & in_rdy;
        out_take = out_vld_q & out_rdy;
        sum      = {1'b0, acc_q} + (aw + 1)'(in);
        carry    = sum[aw];
`ifdef PROD_WIN_ACC_SAT_EN
        add_acc  = carry ? '1 : sum[aw-1:0];
`else
        add_acc  = sum[aw-1:0];
`endif
        win_acc  = acc_in ? add_acc : acc_q;
        win_cnt  = acc_in ? cnt_q + 4'd1 : cnt_q;
        win_ovf  = win_ovf_q | (acc_in & carry);
        // A flush only closes a window that holds at least one sample.
        close    = in_rdy & ((acc_in && win_cnt == 4'(n)) || (flush && win_cnt != 4'd0));
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = win_acc;
        cnt_d     = win_cnt;
        win_ovf_d = win_ovf;
        out_d     = out_q;
        out_cnt_d = out_cnt_q;
        out_vld_d = out_vld_q;
        ovf_d     = ovf_q;
        if (close) begin
            out_d     = win_acc;
            out_cnt_d = win_cnt;
            ovf_d     = win_ovf;
            out_vld_d = 1'b1;
            acc_d     = '0;
            cnt_d     = 4'd0;
            win_ovf_d = 1'b0;
            state_d   = StFull;
        end else begin
            unique case (state_q)
                StIdle: if (acc_in) state_d = StAcc;
                StAcc:  state_d = StAcc;
                StFull: begin
                    if (out_take) begin
                        out_vld_d = 1'b0;
                        state_d   = acc_in ? StAcc : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= 4'd0;
            win_ovf_q <= 1'b0;
            out_q     <= '0;
            out_cnt_q <= 4'd0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            win_ovf_q <= win_ovf_d;
            out_q     <= out_d;
            out_cnt_q <= out_cnt_d;
            out_vld_q <= out_vld_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_prod_win_acc.sv
// Scoreboard bench for prod_win_acc: default instance plus an n=8 instance for overflow.
module tb_prod_win_acc;

    typedef struct packed {
        logic [9:0] sum;
        logic [3:0] cnt;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in = 8'd0;
    logic       in_vld = 1'b0;
    logic       in_rdy;
    logic       flush = 1'b0;
    logic [9:0] out;
    logic [3:0] out_cnt;
    logic       out_vld;
    logic       out_rdy = 1'b1;
    logic       ovf;

    logic [7:0] in1 = 8'd0;
    logic       in_vld1 = 1'b0;
    logic       in_rdy1;
    logic       flush1 = 1'b0;
    logic [9:0] out1;
    logic [3:0] out_cnt1;
    logic       out_vld1;
    logic       out_rdy1 = 1'b1;
    logic       ovf1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prod_win_acc #(.pw(8), .n(4), .aw(10)) dut (
        .clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .in_rdy(in_rdy), .flush(flush),
        .out(out), .out_cnt(out_cnt), .out_vld(out_vld), .out_rdy(out_rdy), .ovf(ovf)
    );

    prod_win_acc #(.pw(8), .n(8), .aw(10)) dut8 (
        .clk(clk), .rst(rst), .in(in1), .in_vld(in_vld1), .in_rdy(in_rdy1), .flush(flush1),
        .out(out1), .out_cnt(out_cnt1), .out_vld(out_vld1), .out_rdy(out_rdy1), .ovf(ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        in     = v;
        in_vld = 1'b1;
        step();
    endtask

    // Monitors: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (q0.size() == 0) begin
                chk("unexpected_window", 32'(out), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("sum", 32'(out), 32'(e.sum));
                chk("cnt", 32'(out_cnt), 32'(e.cnt));
                chk("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_vld1 && out_rdy1) begin
            if (q1.size() == 0) begin
                chk("unexpected_window_n8", 32'(out1), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("sum_n8", 32'(out1), 32'(e.sum));
                chk("cnt_n8", 32'(out_cnt1), 32'(e.cnt));
                chk("ovf_n8", 32'(ovf1), 32'(e.ovf));
            end
        end
    end

    initial begin
        // Reset with live input must not accumulate anything.
        rst    = 1'b1;
        in     = 8'd50;
        in_vld = 1'b1;
        repeat (3) step();
        chk("rst_out", 32'(out), 0);
        chk("rst_out_cnt", 32'(out_cnt), 0);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_in_rdy", 32'(in_rdy), 1);
        in_vld = 1'b0;
        rst    = 1'b0;
        step();

        // Two back-to-back windows with out_rdy held high.
        out_rdy = 1'b1;
        q0.push_back('{sum: 10'd150, cnt: 4'd4, ovf: 1'b0});
        q0.push_back('{sum: 10'd10, cnt: 4'd4, ovf: 1'b0});
        send(8'd50); send(8'd25); send(8'd10); send(8'd65);
        chk("win1_vld", 32'(out_vld), 1);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        in_vld = 1'b0;
        chk("win2_vld", 32'(out_vld), 1);
        step();
        chk("win2_vld_one_cycle", 32'(out_vld), 0);

        // Held output with back-pressure; stalled input must not be taken.
        out_rdy = 1'b0;
        q0.push_back('{sum: 10'd589, cnt: 4'd4, ovf: 1'b0});
        send(8'd169); send(8'd195); send(8'd225); send(8'd0);
        in = 8'd99;
        step();
        chk("stall_in_rdy", 32'(in_rdy), 0);
        chk("stall_out", 32'(out), 589);
        step();
        chk("stall_out_held", 32'(out), 589);
        chk("stall_cnt_held", 32'(out_cnt), 4);
        // 10 is accepted on the same edge the held sum is taken.
        q0.push_back('{sum: 10'd20, cnt: 4'd3, ovf: 1'b0});
        out_rdy = 1'b1;
        send(8'd10);
        send(8'd3);
        flush = 1'b1;
        send(8'd7);
        flush  = 1'b0;
        in_vld = 1'b0;
        chk("flush_vld", 32'(out_vld), 1);
        step();
        flush = 1'b1;
        step();
        chk("idle_flush_vld", 32'(out_vld), 0);
        step();
        chk("idle_flush_vld2", 32'(out_vld), 0);
        flush = 1'b0;

        // Reset drops a held sum, then clears a partial window.
        out_rdy = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        in_vld = 1'b0;
        chk("held_before_rst", 32'(out_vld), 1);
        rst = 1'b1;
        step();
        chk("rst_drop_vld", 32'(out_vld), 0);
        chk("rst_drop_out", 32'(out), 0);
        rst     = 1'b0;
        out_rdy = 1'b1;
        send(8'd5); send(8'd5);
        in_vld = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        q0.push_back('{sum: 10'd4, cnt: 4'd4, ovf: 1'b0});
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        in_vld = 1'b0;

        // n=8 window of 225s: 1800 overflows 10 bits.
`ifdef PROD_WIN_ACC_SAT_EN
        q1.push_back('{sum: 10'd1023, cnt: 4'd8, ovf: 1'b1});
`else
        q1.push_back('{sum: 10'd776, cnt: 4'd8, ovf: 1'b1});
`endif
        in1     = 8'd225;
        in_vld1 = 1'b1;
        repeat (8) step();
        in_vld1 = 1'b0;

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step();
        chk("pending_windows", 32'(q0.size() + q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
